// File: rtl/button_event_arbiter.sv
// rtl/button_event_arbiter.sv - debounced levels to PRESS/RELEASE/LONG events on one round-robin valid/ready channel
module button_event_arbiter #(
  parameter int N_BUTTONS  = 4,
  parameter int ID_W       = 2,
  parameter int LONG_LIMIT = 25000000,
  parameter int CNT_W      = 25
) (
  input  logic                 i_Clk,
  input  logic                 i_Reset,
  input  logic [N_BUTTONS-1:0] i_Buttons,
  input  logic                 i_Evt_Ready,
  input  logic                 i_Clr_Ovf,
  output logic                 o_Evt_Valid,
  output logic [ID_W-1:0]      o_Evt_Id,
  output logic [1:0]           o_Evt_Kind,
  output logic [N_BUTTONS-1:0] o_Pending,
  output logic                 o_Overflow
);

  localparam logic [1:0] KIND_PRESS   = 2'b00;
  localparam logic [1:0] KIND_RELEASE = 2'b01;
  localparam logic [1:0] KIND_LONG    = 2'b10;
  localparam logic [CNT_W-1:0] LONG_CNT = CNT_W'(LONG_LIMIT);

  typedef enum logic {ST_IDLE, ST_OFFER} state_t;

  state_t               state;
  logic [N_BUTTONS-1:0] prev;
  logic [N_BUTTONS-1:0] slot_full;
  logic [1:0]           slot_kind [N_BUTTONS];
  logic [CNT_W-1:0]     hold_cnt  [N_BUTTONS];
  logic [ID_W-1:0]      rr_ptr;

  logic                 grant_found;
  logic                 grant_fire;
  logic [ID_W-1:0]      grant_id;
  logic [ID_W-1:0]      ptr_next;
  logic [N_BUTTONS-1:0] grant_clr;
  logic [N_BUTTONS-1:0] new_evt;
  logic [N_BUTTONS-1:0] overwrite;
  logic [1:0]           new_kind [N_BUTTONS];

  // First full slot at or after rr_ptr, wrapping modulo N_BUTTONS.
  always_comb begin
    int              idx;
    logic [ID_W-1:0] idx_w;
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 0;
    idx_w       = '0;
    for (int i = 0; i < N_BUTTONS; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= N_BUTTONS) idx = idx - N_BUTTONS;
      idx_w = ID_W'(idx);
      if (!grant_found && slot_full[idx_w]) begin
        grant_found = 1'b1;
        grant_id    = idx_w;
      end
    end
  end

  assign grant_fire = grant_found && (state == ST_IDLE || i_Evt_Ready);
  assign ptr_next   = (grant_id == ID_W'(N_BUTTONS - 1)) ? '0 : grant_id + 1'b1;
  assign grant_clr  = grant_fire ? (N_BUTTONS'(1) << grant_id) : '0;
  assign o_Pending  = slot_full;

  always_comb begin
    for (int i = 0; i < N_BUTTONS; i++) begin
      new_evt[i]  = 1'b0;
      new_kind[i] = KIND_PRESS;
      if (i_Buttons[i] && !prev[i]) begin
        new_evt[i] = 1'b1;
      end else if (!i_Buttons[i] && prev[i]) begin
        new_evt[i]  = 1'b1;
        new_kind[i] = KIND_RELEASE;
      end else if (i_Buttons[i] && prev[i] && hold_cnt[i] == LONG_CNT - 1'b1) begin
        new_evt[i]  = 1'b1;
        new_kind[i] = KIND_LONG;
      end
      // A slot drained by this edge's grant can take the new event cleanly.
      overwrite[i] = new_evt[i] && slot_full[i] && !grant_clr[i];
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      prev       <= '0;
      slot_full  <= '0;
      o_Overflow <= 1'b0;
      for (int i = 0; i < N_BUTTONS; i++) begin
        slot_kind[i] <= KIND_PRESS;
        hold_cnt[i]  <= '0;
      end
    end else begin
      prev <= i_Buttons;
      for (int i = 0; i < N_BUTTONS; i++) begin
        if (!i_Buttons[i] || !prev[i]) begin
          hold_cnt[i] <= '0;
        end else if (hold_cnt[i] != LONG_CNT) begin
          hold_cnt[i] <= hold_cnt[i] + 1'b1;
        end
        if (new_evt[i]) begin
          slot_full[i] <= 1'b1;
          slot_kind[i] <= new_kind[i];
        end else if (grant_clr[i]) begin
          slot_full[i] <= 1'b0;
        end
      end
      if (|overwrite) begin
        o_Overflow <= 1'b1;
      end else if (i_Clr_Ovf) begin
        o_Overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      o_Evt_Valid <= 1'b0;
      o_Evt_Id    <= '0;
      o_Evt_Kind  <= KIND_PRESS;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_found) begin
            o_Evt_Valid <= 1'b1;
            o_Evt_Id    <= grant_id;
            o_Evt_Kind  <= slot_kind[grant_id];
            rr_ptr      <= ptr_next;
            state       <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (i_Evt_Ready) begin
            if (grant_found) begin
              o_Evt_Id   <= grant_id;
              o_Evt_Kind <= slot_kind[grant_id];
              rr_ptr     <= ptr_next;
            end else begin
              o_Evt_Valid <= 1'b0;
              state       <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_button_event_arbiter.sv
// tb/tb_button_event_arbiter.sv - scoreboard bench for button_event_arbiter
module tb_button_event_arbiter;

  localparam logic [1:0] K_P = 2'b00;
  localparam logic [1:0] K_R = 2'b01;
  localparam logic [1:0] K_L = 2'b10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] buttons = '0;
  logic       ready = 1'b0;
  logic       clr = 1'b0;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic [1:0] evt_kind;
  logic [3:0] pending;
  logic       overflow;

  int tests = 0;
  int fails = 0;
  logic [3:0] exp_q[$];

  button_event_arbiter #(
    .N_BUTTONS(4), .ID_W(2), .LONG_LIMIT(10), .CNT_W(4)
  ) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Buttons(buttons), .i_Evt_Ready(ready),
    .i_Clr_Ovf(clr), .o_Evt_Valid(evt_valid), .o_Evt_Id(evt_id),
    .o_Evt_Kind(evt_kind), .o_Pending(pending), .o_Overflow(overflow)
  );

  always #5 clk = ~clk;

  // Every accepted beat must match the oldest expected event.
  always @(negedge clk) begin
    if (!rst && evt_valid && ready) begin
      logic [3:0] e;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL beat_unexpected: got id=%0d kind=%0d, expected no beat", evt_id, evt_kind);
      end else begin
        e = exp_q.pop_front();
        if ({evt_id, evt_kind} != e) begin
          fails++;
          $display("FAIL beat: got id=%0d kind=%0d, expected id=%0d kind=%0d",
                   evt_id, evt_kind, e[3:2], e[1:0]);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] id, input logic [1:0] kind);
    exp_q.push_back({id, kind});
  endtask

  task automatic do_reset();
    rst = 1'b1; buttons = '0; ready = 1'b0; clr = 1'b0;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      step(1);
      n++;
    end
    step(3);
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    step(2);
    check("reset_valid", evt_valid, 0);
    check("reset_id", evt_id, 0);
    check("reset_kind", evt_kind, 0);
    check("reset_pending", pending, 0);
    check("reset_overflow", overflow, 0);
    rst = 1'b0;
    step(1);

    // Single press on b2: slot at edge k, valid after k+1, one beat.
    ready = 1'b1;
    buttons[2] = 1'b1; push(2'd2, K_P);
    step(1);
    check("lat_valid_k", evt_valid, 0);
    check("lat_pending_k", pending, 4'b0100);
    step(1);
    check("lat_valid_k1", evt_valid, 1);
    step(1);
    check("one_beat", evt_valid, 0);
    buttons[2] = 1'b0; push(2'd2, K_R);
    drain("drain_b2");

    // b0 and b3 together from ptr=0: 0 then 3 back-to-back, pointer wraps to 0.
    do_reset();
    ready = 1'b1;
    buttons = 4'b1001; push(2'd0, K_P); push(2'd3, K_P);
    step(2);
    check("b2b_first", evt_valid, 1);
    step(1);
    check("b2b_no_bubble", evt_valid, 1);
    buttons = 4'b0000; push(2'd0, K_R); push(2'd3, K_R);
    drain("drain_b03_a");
    buttons = 4'b1001; push(2'd0, K_P); push(2'd3, K_P);
    step(3);
    buttons = 4'b0000; push(2'd0, K_R); push(2'd3, K_R);
    drain("drain_b03_b");

    // Overwrite: b1 PRESS replaced by RELEASE while b0 occupies the channel.
    do_reset();
    ready = 1'b0;
    buttons[0] = 1'b1; push(2'd0, K_P);
    step(3);
    buttons[1] = 1'b1; push(2'd1, K_R);
    step(2);
    buttons[1] = 1'b0;
    step(1);
    check("ovf_set", overflow, 1);
    check("ovf_pending", pending, 4'b0010);
    check("ovf_offer_valid", evt_valid, 1);
    check("ovf_offer_id", evt_id, 0);
    check("ovf_offer_kind", evt_kind, 0);
    buttons[0] = 1'b0; push(2'd0, K_R);
    step(1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("ovf_cleared", overflow, 0);
    check("ovf_pending2", pending, 4'b0011);
    ready = 1'b1;
    drain("drain_ovf");

    // b3 one-cycle pulse: release lands in slot as it is granted, no overflow.
    ready = 1'b0;
    buttons[3] = 1'b1; push(2'd3, K_P); push(2'd3, K_R);
    step(1);
    buttons[3] = 1'b0;
    step(1);
    check("pulse_no_ovf", overflow, 0);
    check("pulse_pending", pending, 4'b1000);
    for (int i = 0; i < 20; i++) begin
      check("stall_valid", evt_valid, 1);
      check("stall_id", evt_id, 3);
      check("stall_kind", evt_kind, 0);
      step(1);
    end
    ready = 1'b1;
    drain("drain_stall");

    // LONG_LIMIT=10: 15-cycle hold gives LONG once; 9-cycle hold gives none.
    buttons[1] = 1'b1; push(2'd1, K_P); push(2'd1, K_L); push(2'd1, K_R);
    step(15);
    buttons[1] = 1'b0;
    drain("drain_long15");
    buttons[1] = 1'b1; push(2'd1, K_P); push(2'd1, K_R);
    step(9);
    buttons[1] = 1'b0;
    drain("drain_long9");

    // Reset during OFFER drops the offer immediately.
    ready = 1'b0;
    buttons[2] = 1'b1;
    step(3);
    check("pre_rst_valid", evt_valid, 1);
    rst = 1'b1;
    buttons = '0;
    #1;
    check("rst_async_valid", evt_valid, 0);
    check("rst_async_id", evt_id, 0);
    check("rst_async_pending", pending, 0);
    step(2);
    rst = 1'b0;
    ready = 1'b1;
    step(5);
    check("post_rst_valid", evt_valid, 0);
    check("post_rst_pending", pending, 0);
    drain("drain_final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
